// File: rtl/mixer_pkg.sv
// Shared width defaults and fixed-point helpers for the MLP-mixer datapath.
package mixer_pkg;

    localparam int A_BITS_DEF   = 8;
    localparam int B_BITS_DEF   = 8;
    localparam int ACC_BITS_DEF = 24;
    localparam int OUT_BITS_DEF = 16;
    localparam int LEN_BITS_DEF = 8;

    // Arithmetic right shift with round-half-up; sh = 0 passes the value through.
    // Worked at 64 bits so any accumulator up to 62 bits gets its one guard bit.
    function automatic logic signed [63:0] round_shr(input logic signed [63:0] x,
                                                     input int sh);
        logic signed [63:0] r;
        if (sh > 0)
            r = (x + (64'sd1 <<< (sh - 1))) >>> sh;
        else
            r = x;
        return r;
    endfunction

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi)
            r = hi;
        else if (x < lo)
            r = lo;
        else
            r = x;
        return r;
    endfunction

endpackage

// File: rtl/mac_product_stage.sv
// S1 of the MAC pipeline: registered full-width signed product plus its
// first/last/shift tags, frozen while the downstream pipeline is stalled.
module mac_product_stage #(
    parameter int A_BITS  = 8,
    parameter int B_BITS  = 8,
    parameter int SH_BITS = 5
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_hold,
    input  logic                             i_vld,
    input  logic signed [A_BITS-1:0]         i_a,
    input  logic signed [B_BITS-1:0]         i_b,
    input  logic                             i_first,
    input  logic                             i_last,
    input  logic [SH_BITS-1:0]               i_shift,
    output logic                             o_vld_p1,
    output logic signed [A_BITS+B_BITS-1:0]  o_prod_p1,
    output logic                             o_first_p1,
    output logic                             o_last_p1,
    output logic [SH_BITS-1:0]               o_shift_p1
);

    logic signed [A_BITS+B_BITS-1:0] w_prod;

    assign w_prod = i_a * i_b;

    // Stage valid: advances with the pipeline, frozen on hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_vld_p1 <= 1'b0;
        else if (!i_hold)
            o_vld_p1 <= i_vld;
    end

    // Product and tags: only captured for a real beat, so bubbles leave them untouched.
    always_ff @(posedge clk) begin
        if (!i_hold && i_vld) begin
            o_prod_p1  <= w_prod;
            o_first_p1 <= i_first;
            o_last_p1  <= i_last;
            o_shift_p1 <= i_shift;
        end
    end

endmodule

// File: rtl/mac_accum_pipeline.sv
// Signed multiply-accumulate over last-delimited vectors, then round, shift
// and saturate one result per vector. Pipeline: S1 product, S2 accumulate,
// S3 round/shift, output register with saturation.
module mac_accum_pipeline
    import mixer_pkg::*;
#(
    parameter int A_BITS   = A_BITS_DEF,
    parameter int B_BITS   = B_BITS_DEF,
    parameter int ACC_BITS = ACC_BITS_DEF,
    parameter int OUT_BITS = OUT_BITS_DEF,
    parameter int LEN_BITS = LEN_BITS_DEF,
    parameter int SH_BITS  = $clog2(ACC_BITS)
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [A_BITS-1:0]   in_a,
    input  logic signed [B_BITS-1:0]   in_b,
    input  logic                       in_last,
    input  logic [SH_BITS-1:0]         in_shift,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_BITS-1:0] out_data,
    output logic                       out_sat,
    output logic [LEN_BITS-1:0]        out_len
);

    logic                             w_stall;
    logic                             w_fire;
    logic                             r_first_pend;

    logic                             w_vld_p1;
    logic signed [A_BITS+B_BITS-1:0]  w_prod_p1;
    logic                             w_first_p1;
    logic                             w_last_p1;
    logic [SH_BITS-1:0]               w_shift_p1;
    logic signed [ACC_BITS-1:0]       w_prod_ext;

    logic                             r_vld_p2;
    logic                             r_last_p2;
    logic signed [ACC_BITS-1:0]       r_acc_p2;
    logic [LEN_BITS-1:0]              r_len_p2;
    logic [SH_BITS-1:0]               r_sh_p2;

    logic                             r_vld_p3;
    logic signed [ACC_BITS:0]         r_rnd_p3;
    logic [LEN_BITS-1:0]              r_len_p3;

    logic signed [63:0]               w_rnd_wide;
    logic signed [63:0]               w_rnd_p3_wide;
    logic signed [63:0]               w_sat_wide;
    logic                             w_sat;
    logic                             w_unused_bits;

    // Backpressure freezes every stage at once, so in_ready depends only on the output side.
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_fire   = in_valid & in_ready;

    assign w_prod_ext    = ACC_BITS'(w_prod_p1);
    assign w_rnd_wide    = round_shr(64'(r_acc_p2), int'(r_sh_p2));
    assign w_rnd_p3_wide = 64'(r_rnd_p3);
    assign w_sat_wide    = sat_signed(w_rnd_p3_wide, OUT_BITS);
    assign w_sat         = (w_sat_wide != w_rnd_p3_wide);
    // Sign-duplicate high bits of the wide helpers carry no information.
    assign w_unused_bits = ^{w_rnd_wide[63:ACC_BITS+1], w_sat_wide[63:OUT_BITS]};

    // Track vector boundaries: the beat after reset or after a last beat is a first beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_first_pend <= 1'b1;
        else if (w_fire)
            r_first_pend <= in_last;
    end

    // ---- S1: product register ----
    mac_product_stage #(
        .A_BITS (A_BITS),
        .B_BITS (B_BITS),
        .SH_BITS(SH_BITS)
    ) u_product (
        .clk       (clk),
        .rst       (rst),
        .i_hold    (w_stall),
        .i_vld     (w_fire),
        .i_a       (in_a),
        .i_b       (in_b),
        .i_first   (r_first_pend),
        .i_last    (in_last),
        .i_shift   (in_shift),
        .o_vld_p1  (w_vld_p1),
        .o_prod_p1 (w_prod_p1),
        .o_first_p1(w_first_p1),
        .o_last_p1 (w_last_p1),
        .o_shift_p1(w_shift_p1)
    );

    // ---- S2: accumulate; shift amount latched from the first beat only ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
            r_acc_p2  <= '0;
            r_len_p2  <= '0;
            r_sh_p2   <= '0;
        end else if (!w_stall) begin
            r_vld_p2 <= w_vld_p1;
            if (w_vld_p1) begin
                r_last_p2 <= w_last_p1;
                if (w_first_p1) begin
                    r_acc_p2 <= w_prod_ext;
                    r_len_p2 <= LEN_BITS'(1);
                    r_sh_p2  <= w_shift_p1;
                end else begin
                    r_acc_p2 <= r_acc_p2 + w_prod_ext;
                    r_len_p2 <= r_len_p2 + LEN_BITS'(1);
                end
            end
        end
    end

    // ---- S3: round and shift the finished sum of a vector ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_vld_p3 <= 1'b0;
        else if (!w_stall)
            r_vld_p3 <= r_vld_p2 & r_last_p2;
    end

    // S3 data: captured only when a vector completes.
    always_ff @(posedge clk) begin
        if (!w_stall && r_vld_p2 && r_last_p2) begin
            r_rnd_p3 <= w_rnd_wide[ACC_BITS:0];
            r_len_p3 <= r_len_p2;
        end
    end

    // ---- Output register: saturate; loads straight over an accepted result ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_len   <= '0;
        end else if (!w_stall) begin
            out_valid <= r_vld_p3;
            if (r_vld_p3) begin
                out_data <= w_sat_wide[OUT_BITS-1:0];
                out_sat  <= w_sat;
                out_len  <= r_len_p3;
            end
        end
    end

endmodule
